// File: rtl/hazard_sb_pkg.sv
// Shared types for the hazard scoreboard: generic scalar types in common,
// pipeline control bundle and scoreboard state in pipes.
package common;
  typedef logic        u1;
  typedef logic [31:0] word_t;

  localparam int ZERO_REG = 31;
endpackage

package pipes;
  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_BUSY = 1'b1
  } sb_state_t;

  typedef struct packed {
    logic stallF;
    logic stallD;
    logic stallE;
    logic stallM;
    logic flushD;
    logic flushE;
    logic flushW;
  } hazard_ctrl_t;
endpackage

// File: rtl/hazard_sb_match.sv
// NSRC-way comparator: does any enabled, non-zero-register source equal idx_i?
module sb_match #(
  parameter int NSRC     = 3,
  parameter int AW       = 5,
  parameter int ZERO_REG = 31
) (
  input  logic [NSRC*AW-1:0] src_i,
  input  logic [NSRC-1:0]    src_en_i,
  input  logic [AW-1:0]      idx_i,
  output logic               hit_o
);

  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_en_i[i] && (src_i[i*AW +: AW] != AW'(ZERO_REG)) && (src_i[i*AW +: AW] == idx_i)) begin
        hit_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_sb.sv
// Hazard unit with a single-entry scoreboard tracking one outstanding
// variable-latency mul/div result.
module hazard_sb
  import pipes::*;
#(
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int NSRC     = 3,
  parameter int ZERO_REG = common::ZERO_REG,
  parameter int CW       = 32
) (
  input  common::u1          clk,
  input  common::u1          reset,
  input  logic               ireq_valid,
  input  logic               iresp_data_ok,
  input  logic               dreq_valid,
  input  logic               dresp_data_ok,
  input  logic               d_valid,
  input  logic [NSRC*AW-1:0] d_src,
  input  logic [NSRC-1:0]    d_src_en,
  input  logic [AW-1:0]      d_dst,
  input  logic               d_regwrite,
  input  logic               d_multi,
  input  logic [AW-1:0]      e_dst,
  input  logic               e_regwrite,
  input  logic               e_memtoreg,
  input  logic               md_done,
  input  logic               redirect,
  output logic               stallF,
  output logic               stallD,
  output logic               stallE,
  output logic               stallM,
  output logic               flushD,
  output logic               flushE,
  output logic               flushW,
  output logic               md_issue,
  output logic               sb_busy,
  output logic [AW-1:0]      sb_dst,
  output logic               sb_err,
  output logic [CW-1:0]      stall_cnt
);

  sb_state_t    state_q, state_d;
  logic [AW-1:0] sb_dst_q, sb_dst_d;
  logic          sb_err_q, sb_err_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;

  hazard_ctrl_t ctrl;
  logic memwait, fetchwait, loaduse, sbhaz;
  logic e_hit, sb_hit;

  sb_match #(.NSRC(NSRC), .AW(AW), .ZERO_REG(ZERO_REG)) u_e_match (
    .src_i    (d_src),
    .src_en_i (d_src_en),
    .idx_i    (e_dst),
    .hit_o    (e_hit)
  );

  sb_match #(.NSRC(NSRC), .AW(AW), .ZERO_REG(ZERO_REG)) u_sb_match (
    .src_i    (d_src),
    .src_en_i (d_src_en),
    .idx_i    (sb_dst_q),
    .hit_o    (sb_hit)
  );

  assign memwait   = dreq_valid & ~dresp_data_ok;
  assign fetchwait = ireq_valid & ~iresp_data_ok;
  assign loaduse   = d_valid & e_regwrite & e_memtoreg & e_hit;
  // md_done bypasses the result this cycle, so every scoreboard hazard clears.
  assign sbhaz     = d_valid & (state_q == SB_BUSY) & ~md_done &
                     (sb_hit | (d_regwrite & (d_dst == sb_dst_q)) | d_multi);

  always_comb begin
    ctrl = '0;
    if (memwait) begin
      ctrl.stallF = 1'b1;
      ctrl.stallD = 1'b1;
      ctrl.stallE = 1'b1;
      ctrl.stallM = 1'b1;
      ctrl.flushW = 1'b1;
    end else if (redirect) begin
      ctrl.flushD = 1'b1;
    end else if (loaduse || sbhaz) begin
      ctrl.stallF = 1'b1;
      ctrl.stallD = 1'b1;
      ctrl.flushE = 1'b1;
    end else if (fetchwait) begin
      ctrl.stallF = 1'b1;
      ctrl.flushD = 1'b1;
    end
  end

  assign md_issue = d_valid & d_multi & ~ctrl.stallD & ~ctrl.flushD & ~memwait;

  always_comb begin
    state_d  = state_q;
    sb_dst_d = sb_dst_q;
    sb_err_d = sb_err_q;
    case (state_q)
      SB_IDLE: begin
        if (md_done) sb_err_d = 1'b1;
        if (md_issue) begin
          state_d  = SB_BUSY;
          sb_dst_d = d_dst;
        end
      end
      SB_BUSY: begin
        if (md_done) begin
          if (md_issue) sb_dst_d = d_dst;
          else          state_d  = SB_IDLE;
        end
      end
      default: state_d = SB_IDLE;
    endcase
    stall_cnt_d = stall_cnt_q;
    if (ctrl.stallD && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SB_IDLE;
      sb_dst_q    <= '0;
      sb_err_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sb_dst_q    <= sb_dst_d;
      sb_err_q    <= sb_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stallF    = ctrl.stallF;
  assign stallD    = ctrl.stallD;
  assign stallE    = ctrl.stallE;
  assign stallM    = ctrl.stallM;
  assign flushD    = ctrl.flushD;
  assign flushE    = ctrl.flushE;
  assign flushW    = ctrl.flushW;
  assign sb_busy   = (state_q == SB_BUSY);
  assign sb_dst    = sb_dst_q;
  assign sb_err    = sb_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule
